mem_responder_4b: RTL and testbench
===================================

MEM_RESPONDER_4B -- requirements
Module: mem_responder_4b

Interface
REQ-001 SHALL have parameter AW, default 10: word-address width; the array holds 2^AW 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request accept to earliest response valid; legal range 1..8.
REQ-003 SHALL have parameter DEPTH, default 4: maximum outstanding transactions; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port memreq_msg, input, mem_req_4B_t: request with fields type (0 read, 1 write), opaque, addr, len, data.
REQ-007 SHALL have port memreq_val, input, 1 bit: request valid.
REQ-008 SHALL have port memreq_rdy, output, 1 bit: responder can accept a request.
REQ-009 SHALL have port memresp_msg, output, mem_resp_4B_t: response with fields type, opaque, test, len, data.
REQ-010 SHALL have port memresp_val, output, 1 bit: response valid.
REQ-011 SHALL have port memresp_rdy, input, 1 bit: requester accepts the response.

Function
REQ-012 SHALL accept a request only in a cycle where memreq_val && memreq_rdy (accept).
REQ-013 SHALL drive memreq_rdy = (outstanding < DEPTH), derived from registered state only and independent of memreq_val and memresp_rdy in the same cycle.
REQ-014 SHALL keep a counter outstanding of width log2(DEPTH)+1: +1 on accept, -1 on response handshake, unchanged when both or neither occur in a cycle.
REQ-015 SHALL, for a read (type 0), return mem[addr[AW+1:2]] as it stands after all writes accepted in earlier cycles.
REQ-016 SHALL apply a write (type 1) at the clock edge that ends its accept cycle.
REQ-017 SHALL encode write len as: 0 = 4 bytes; 1 = 1 byte at lane addr[1:0]; 2 = 2 bytes at lane addr[1] (halfword); bytes come from data[7:0] or data[15:0] respectively. Other bytes are unchanged.
REQ-018 SHALL, for a read with len 1 or 2, return the selected byte or halfword zero-extended in data[7:0] or data[15:0].
REQ-019 SHALL ignore address bits above AW+1, so addresses wrap modulo 2^(AW+2) bytes.
REQ-020 SHALL build each response as: type, opaque and len copied from the request; test = 0; data = read data for reads and 0 for writes.
REQ-021 SHALL, for a request type other than 0 or 1, leave memory unmodified and return a response with test = 2'b11 and data = 0.
REQ-022 SHALL pass each accepted transaction through a LATENCY-stage valid/data delay line, then into a DEPTH-entry response FIFO.
REQ-023 SHALL make the response to a request accepted in cycle t visible at memresp_val no earlier than cycle t+LATENCY, and exactly at t+LATENCY when the FIFO is empty and memresp_rdy is high.
REQ-024 SHALL return responses strictly in accept order.
REQ-025 SHALL hold memresp_val and memresp_msg stable while memresp_val && !memresp_rdy.
REQ-026 SHALL allow one accept and one response handshake in the same cycle with no bubble; sustained throughput is 1 transaction per cycle when memresp_rdy is held high.
REQ-027 SHALL never overflow the FIFO; this is guaranteed by the credit rule in REQ-013.
REQ-028 SHALL drive memresp_val = (FIFO not empty).

Reset
REQ-029 SHALL, while rst is high: clear outstanding, the FIFO pointers and every delay-line valid bit; memreq_rdy = 0; memresp_val = 0.
REQ-030 SHALL discard in-flight transactions when rst is asserted mid-operation; no response for them ever appears.
REQ-031 SHALL not clear memory contents on reset, and SHALL drive memreq_rdy = 1 in the first cycle after rst falls.
REQ-032 SHALL ignore any request presented while rst is high.

Verification
REQ-033 Write then read (LATENCY=1): write addr 0x10, data 0xDEADBEEF, len 0, opaque 3, then read addr 0x10, opaque 4 -> two responses in order; the read returns data 0xDEADBEEF, opaque 4, test 0.
REQ-034 Byte write: write 0x000000AB, len 1, to addr 0x11 over an existing word 0xDEADBEEF -> a later full-word read of 0x10 returns 0xDEADABEF; a len-1 read of 0x11 returns 0x000000AB.
REQ-035 Backpressure (DEPTH=4): memresp_rdy = 0 and 6 back-to-back reads -> exactly 4 accepts, memreq_rdy = 0 afterwards; raise memresp_rdy -> 4 responses in order, and memreq_rdy returns to 1 the cycle after the first response handshake.
REQ-036 Full throughput (LATENCY=3): 16 consecutive reads with memresp_rdy held high -> the first memresp_val arrives 3 cycles after the first accept, followed by 16 consecutive response cycles.
REQ-037 Reset mid-flight: accept 2 reads, assert rst for 1 cycle before any response -> no response for either read; memresp_val = 0 and memreq_rdy = 1 in the cycle after rst falls.
REQ-038 Illegal type: request with type 3 -> response with test 2'b11 and data 0; a subsequent read of the same address shows memory unchanged.

Source files
------------

// File: rtl/mem_responder_4b.sv
// Single-ported word memory behind a valid/ready request/response interface.
// Responses pass through a fixed-latency delay line into a credit-protected FIFO.

package mem_msgs_4b_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module mem_responder_4b
    import mem_msgs_4b_pkg::*;
#(
    parameter int AW      = 10,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_4B_t  memreq_msg,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    output mem_resp_4B_t memresp_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [31:0]  mem [0:(1 << AW) - 1];
    mem_resp_4B_t fifo_mem [0:DEPTH - 1];

    logic [PW:0]  outstanding;
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    logic         accept;
    logic         resp_fire;
    logic         fifo_push;
    mem_resp_4B_t fifo_din;
    mem_resp_4B_t resp_new;
    logic [AW-1:0] word_idx;
    logic [1:0]   lane;
    logic [31:0]  rd_word;
    logic [31:0]  wr_word;
    logic         unused_addr_bits;

    // rst gates the handshakes combinationally so nothing is accepted or offered while it is held.
    assign memreq_rdy  = !rst && (outstanding < DEPTH_CNT);
    assign memresp_val = !rst && (wr_ptr != rd_ptr);
    assign memresp_msg = fifo_mem[rd_ptr[PW-1:0]];

    assign accept    = memreq_val && memreq_rdy;
    assign resp_fire = memresp_val && memresp_rdy;

    assign word_idx         = memreq_msg.addr[AW+1:2];
    assign lane             = memreq_msg.addr[1:0];
    assign rd_word          = mem[word_idx];
    assign unused_addr_bits = ^memreq_msg.addr[31:AW+2];

    // Build the response and the merged write word from the pre-write memory contents.
    always_comb begin
        resp_new        = '0;
        resp_new.typ    = memreq_msg.typ;
        resp_new.opaque = memreq_msg.opaque;
        resp_new.len    = memreq_msg.len;
        wr_word         = rd_word;
        case (memreq_msg.typ)
            3'd0: begin
                case (memreq_msg.len)
                    2'd1:    resp_new.data = {24'd0, rd_word[{lane, 3'b000} +: 8]};
                    2'd2:    resp_new.data = {16'd0, rd_word[{lane[1], 4'b0000} +: 16]};
                    default: resp_new.data = rd_word;
                endcase
            end
            3'd1: begin
                case (memreq_msg.len)
                    2'd1:    wr_word[{lane, 3'b000} +: 8]      = memreq_msg.data[7:0];
                    2'd2:    wr_word[{lane[1], 4'b0000} +: 16] = memreq_msg.data[15:0];
                    default: wr_word                            = memreq_msg.data;
                endcase
            end
            default: resp_new.test = 2'b11;
        endcase
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && (memreq_msg.typ == 3'd1)) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Credit counter: covers everything in the delay line plus the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The FIFO write is itself the last latency stage, so only LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_push = accept;
            assign fifo_din  = resp_new;
        end else begin : g_delay
            logic [LATENCY-2:0] stage_val;
            mem_resp_4B_t       stage_msg [0:LATENCY-2];

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_val <= '0;
                end else begin
                    stage_val[0] <= accept;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        stage_val[k] <= stage_val[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                stage_msg[0] <= resp_new;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    stage_msg[k] <= stage_msg[k-1];
                end
            end

            assign fifo_push = stage_val[LATENCY-2];
            assign fifo_din  = stage_msg[LATENCY-2];
        end
    endgenerate

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= fifo_din;
        end
    end

endmodule

// File: tb/tb_mem_responder_4b.sv
// Self-checking bench for mem_responder_4b against a byte-addressed reference memory
// and an in-order expected-response queue.
module tb_mem_responder_4b;
    import mem_msgs_4b_pkg::*;

    localparam int TB_AW    = 6;
    localparam int TB_LAT   = 3;
    localparam int TB_DEPTH = 4;
    localparam int NBYTES   = 1 << (TB_AW + 2);

    logic         clk;
    logic         rst;
    mem_req_4B_t  memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    mem_resp_4B_t memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;

    mem_responder_4b #(.AW(TB_AW), .LATENCY(TB_LAT), .DEPTH(TB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ref_out = 0;
    int rdy_viol = 0;
    int stall_viol = 0;

    logic [7:0]   ref_mem [0:NBYTES-1];
    mem_req_4B_t  req_q[$];
    mem_resp_4B_t exp_q[$];
    mem_resp_4B_t obs_q[$];
    int           acc_cyc_q[$];
    int           resp_cyc_q[$];

    logic         s_rdy, s_val, s_acc, s_fire, prev_stall;
    mem_resp_4B_t s_msg, prev_msg;

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        mem_req_4B_t r;
        r.typ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
        return r;
    endfunction

    // Reference: byte-addressed memory, address taken modulo the array size in bytes.
    function automatic mem_resp_4B_t model_accept(input mem_req_4B_t r);
        mem_resp_4B_t p;
        int nb;
        int start;
        int base;
        base = int'(r.addr) % NBYTES;
        if (base < 0) base = base + NBYTES;
        case (r.len)
            2'd1:    begin nb = 1; start = base; end
            2'd2:    begin nb = 2; start = (base / 2) * 2; end
            default: begin nb = 4; start = (base / 4) * 4; end
        endcase
        p = '0;
        p.typ = r.typ; p.opaque = r.opaque; p.len = r.len;
        if (r.typ == 3'd0) begin
            for (int i = 0; i < nb; i++) p.data[8*i +: 8] = ref_mem[start + i];
        end else if (r.typ == 3'd1) begin
            for (int i = 0; i < nb; i++) ref_mem[start + i] = r.data[8*i +: 8];
        end else begin
            p.test = 2'b11;
        end
        return p;
    endfunction

    // One clock cycle: sample at negedge, record handshakes, advance past the posedge.
    task automatic step();
        @(negedge clk);
        s_rdy  = memreq_rdy;
        s_val  = memresp_val;
        s_msg  = memresp_msg;
        s_acc  = memreq_val && memreq_rdy;
        s_fire = memresp_val && memresp_rdy;
        if (prev_stall && (!s_val || (s_msg !== prev_msg))) stall_viol++;
        if (s_rdy !== (!rst && (ref_out < TB_DEPTH))) rdy_viol++;
        if (s_fire === 1'b1) begin obs_q.push_back(s_msg); resp_cyc_q.push_back(cyc); end
        if (s_acc === 1'b1) begin exp_q.push_back(model_accept(memreq_msg)); acc_cyc_q.push_back(cyc); end
        prev_stall = s_val && !memresp_rdy;
        prev_msg   = s_msg;
        if (rst) begin
            ref_out = 0; prev_stall = 1'b0;
        end else begin
            ref_out = ref_out + int'(s_acc) - int'(s_fire);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); resp_cyc_q.delete();
    endtask

    task automatic run_stream(input int rdy_pct);
        int budget = 0;
        while ((req_q.size() > 0 || exp_q.size() > obs_q.size()) && budget < 3000) begin
            memreq_val = (req_q.size() > 0);
            if (req_q.size() > 0) memreq_msg = req_q[0];
            memresp_rdy = ($urandom_range(0, 99) < rdy_pct);
            step();
            if (s_acc) void'(req_q.pop_front());
            budget++;
        end
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        req_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; memresp_rdy = 1'b1; memreq_val = 1'b1;
        memreq_msg = mk_req(3'd1, 8'd9, 32'h20, 2'd0, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", s_rdy); end
            checks++; if (s_val !== 1'b0) begin failures++; $display("FAIL reset_val: got %b expected 0", s_val); end
        end
        rst = 1'b0; memreq_val = 1'b0;
        step();
        checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL post_reset_rdy: got %b expected 1", s_rdy); end
        checks++; if (s_val !== 1'b0) begin failures++; $display("FAIL post_reset_val: got %b expected 0", s_val); end
        clear_q();
    endtask

    task automatic test_preload();
        clear_q();
        for (int w = 0; w < (1 << TB_AW); w++)
            req_q.push_back(mk_req(3'd1, 8'(w), {$urandom_range(0, 255), 16'h0000, 8'(w * 4)}, 2'd0, $urandom));
        run_stream(100);
        checks++; if (obs_q.size() != (1 << TB_AW)) begin failures++; $display("FAIL preload_count: got %0d expected %0d", obs_q.size(), 1 << TB_AW); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL preload_resp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_write_read();
        clear_q();
        req_q.push_back(mk_req(3'd1, 8'd3, 32'h10, 2'd0, 32'hDEAD_BEEF));
        req_q.push_back(mk_req(3'd0, 8'd4, 32'h10, 2'd0, 32'h0));
        run_stream(100);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL wr_rd_count: got %0d expected 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].opaque !== 8'd3 || obs_q[0].typ !== 3'd1 || obs_q[0].data !== 32'h0) begin failures++; $display("FAIL wr_resp: got %h expected typ 1 opaque 3 data 0", obs_q[0]); end
            checks++; if (obs_q[1].data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", obs_q[1].data); end
            checks++; if (obs_q[1].opaque !== 8'd4 || obs_q[1].test !== 2'b00) begin failures++; $display("FAIL rd_fields: got %h expected opaque 4 test 0", obs_q[1]); end
            checks++; if (obs_q[1] !== exp_q[1]) begin failures++; $display("FAIL rd_model: got %h expected %h", obs_q[1], exp_q[1]); end
            checks++; if (resp_cyc_q[0] - acc_cyc_q[0] != TB_LAT) begin failures++; $display("FAIL latency_exact: got %0d expected %0d", resp_cyc_q[0] - acc_cyc_q[0], TB_LAT); end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] want [0:3];
        want[0] = 32'h0; want[1] = 32'hDEAD_ABEF; want[2] = 32'h0000_00AB; want[3] = 32'h0000_DEAD;
        clear_q();
        req_q.push_back(mk_req(3'd1, 8'd10, 32'h11, 2'd1, 32'h0000_00AB));
        req_q.push_back(mk_req(3'd0, 8'd11, 32'h10, 2'd0, 32'h0));
        req_q.push_back(mk_req(3'd0, 8'd12, 32'h11, 2'd1, 32'h0));
        req_q.push_back(mk_req(3'd0, 8'd13, 32'h12, 2'd2, 32'h0));
        run_stream(100);
        checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL byte_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++; if (obs_q[i].data !== want[i] || obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL byte_resp[%0d]: got %h expected data %h model %h", i, obs_q[i], want[i], exp_q[i]); end
        end
    endtask

    task automatic test_illegal();
        clear_q();
        req_q.push_back(mk_req(3'd3, 8'd20, 32'h10, 2'd0, 32'h5555_5555));
        req_q.push_back(mk_req(3'd0, 8'd21, 32'h10, 2'd0, 32'h0));
        run_stream(100);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL illegal_count: got %0d expected 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].test !== 2'b11 || obs_q[0].data !== 32'h0 || obs_q[0].typ !== 3'd3) begin failures++; $display("FAIL illegal_resp: got %h expected test 3 data 0", obs_q[0]); end
            checks++; if (obs_q[1].data !== 32'hDEAD_ABEF) begin failures++; $display("FAIL illegal_mem: got %h expected deadabef", obs_q[1].data); end
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int first_fire = -1;
        logic rdy_at_fire = 1'bx;
        logic rdy_after = 1'bx;
        clear_q();
        memresp_rdy = 1'b0;
        for (int i = 0; i < 6; i++) req_q.push_back(mk_req(3'd0, 8'(40 + i), $urandom, 2'd0, 32'h0));
        for (int c = 0; c < 8; c++) begin
            memreq_val = 1'b1; memreq_msg = req_q[0];
            step();
            if (s_acc) begin n_acc++; void'(req_q.pop_front()); end
        end
        checks++; if (n_acc != TB_DEPTH) begin failures++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, TB_DEPTH); end
        checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_low: got %b expected 0", s_rdy); end
        req_q.delete();
        memreq_val = 1'b0; memresp_rdy = 1'b1;
        for (int c = 0; c < 20 && obs_q.size() < TB_DEPTH + 1; c++) begin
            step();
            if (s_fire && first_fire < 0) begin first_fire = c; rdy_at_fire = s_rdy; end
            else if (first_fire >= 0 && c == first_fire + 1) rdy_after = s_rdy;
            if (obs_q.size() >= TB_DEPTH && c > first_fire + 1 && first_fire >= 0) break;
        end
        checks++; if (rdy_at_fire !== 1'b0) begin failures++; $display("FAIL bp_rdy_at_fire: got %b expected 0", rdy_at_fire); end
        checks++; if (rdy_after !== 1'b1) begin failures++; $display("FAIL bp_rdy_after_fire: got %b expected 1", rdy_after); end
        checks++; if (obs_q.size() != TB_DEPTH) begin failures++; $display("FAIL bp_resp_count: got %0d expected %0d", obs_q.size(), TB_DEPTH); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_resp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_throughput();
        clear_q();
        for (int i = 0; i < 16; i++) req_q.push_back(mk_req(3'd0, 8'(60 + i), $urandom, 2'($urandom_range(0, 2)), 32'h0));
        run_stream(100);
        checks++; if (obs_q.size() != 16 || acc_cyc_q.size() != 16) begin failures++; $display("FAIL tp_count: got %0d/%0d expected 16", acc_cyc_q.size(), obs_q.size()); end
        else begin
            checks++; if (acc_cyc_q[15] - acc_cyc_q[0] != 15) begin failures++; $display("FAIL tp_accept_span: got %0d expected 15", acc_cyc_q[15] - acc_cyc_q[0]); end
            checks++; if (resp_cyc_q[0] - acc_cyc_q[0] != TB_LAT) begin failures++; $display("FAIL tp_first_latency: got %0d expected %0d", resp_cyc_q[0] - acc_cyc_q[0], TB_LAT); end
            checks++; if (resp_cyc_q[15] - resp_cyc_q[0] != 15) begin failures++; $display("FAIL tp_resp_span: got %0d expected 15", resp_cyc_q[15] - resp_cyc_q[0]); end
            for (int i = 0; i < 16; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL tp_resp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        memresp_rdy = 1'b1; memreq_val = 1'b1;
        memreq_msg = mk_req(3'd0, 8'd70, 32'h10, 2'd0, 32'h0); step();
        memreq_msg = mk_req(3'd0, 8'd71, 32'h14, 2'd0, 32'h0); step();
        checks++; if (acc_cyc_q.size() != 2) begin failures++; $display("FAIL mid_accepts: got %0d expected 2", acc_cyc_q.size()); end
        rst = 1'b1;
        memreq_msg = mk_req(3'd1, 8'd72, 32'h10, 2'd0, 32'h1234_5678);
        step();
        checks++; if (s_rdy !== 1'b0 || s_val !== 1'b0) begin failures++; $display("FAIL mid_in_reset: got rdy %b val %b expected 0 0", s_rdy, s_val); end
        clear_q();
        rst = 1'b0; memreq_val = 1'b0;
        step();
        checks++; if (s_val !== 1'b0) begin failures++; $display("FAIL mid_post_val: got %b expected 0", s_val); end
        checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL mid_post_rdy: got %b expected 1", s_rdy); end
        for (int c = 0; c < 8; c++) step();
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_ghost_resp: got %0d expected 0", obs_q.size()); end
        clear_q();
        req_q.push_back(mk_req(3'd0, 8'd73, 32'h10, 2'd0, 32'h0));
        run_stream(100);
        checks++; if (obs_q.size() != 1 || obs_q[0].data !== 32'hDEAD_ABEF) begin failures++; $display("FAIL mid_mem_kept: got %0d resp data %h expected deadabef", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0); end
    endtask

    task automatic test_random_traffic();
        int bad_lat = 0;
        int r;
        clear_q();
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            req_q.push_back(mk_req((r < 5) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom_range(2, 7)),
                                   8'($urandom), $urandom, 2'($urandom_range(0, 2)), $urandom));
        end
        run_stream(60);
        checks++; if (obs_q.size() != 200) begin failures++; $display("FAIL rnd_count: got %0d expected 200", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_resp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
            if (resp_cyc_q[i] - acc_cyc_q[i] < TB_LAT) bad_lat++;
        end
        checks++; if (bad_lat != 0) begin failures++; $display("FAIL rnd_latency: got %0d early responses expected 0", bad_lat); end
    endtask

    task automatic test_invariants();
        checks++; if (rdy_viol != 0) begin failures++; $display("FAIL credit_rdy: got %0d wrong cycles expected 0", rdy_viol); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL resp_stable: got %0d unstable cycles expected 0", stall_viol); end
    endtask

    initial begin
        rst = 1'b1; memreq_val = 1'b0; memresp_rdy = 1'b0; memreq_msg = '0;
        prev_stall = 1'b0; prev_msg = '0;
        test_reset();
        test_preload();
        test_write_read();
        test_byte_write();
        test_illegal();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
        test_random_traffic();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
